// File: rtl/inc_dec_pkg.sv
// rtl/inc_dec_pkg.sv - shared constants, parser state and opcode types for inc_dec_bank
//
// Contents:
//   ASC_*         ASCII bytes recognised by the command parser
//   state_t       parser FSM states
//   op_t          decoded command opcode
//   start_state() state reached when a byte is evaluated as the start of a command
package inc_dec_pkg;

    localparam logic [7:0] ASC_I = 8'h49;
    localparam logic [7:0] ASC_N = 8'h4E;
    localparam logic [7:0] ASC_C = 8'h43;
    localparam logic [7:0] ASC_D = 8'h44;
    localparam logic [7:0] ASC_E = 8'h45;
    localparam logic [7:0] ASC_L = 8'h4C;
    localparam logic [7:0] ASC_R = 8'h52;
    localparam logic [7:0] ASC_0 = 8'h30;
    localparam logic [7:0] ASC_9 = 8'h39;

    typedef enum logic [3:0] {
        IDLE,
        S_I,
        S_IN,
        S_D,
        S_DE,
        S_C,
        S_CL,
        W_INC,
        W_DEC,
        W_CLR
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_INC,
        OP_DEC,
        OP_CLR
    } op_t;

    // Any byte that breaks a partial command is retried as a fresh start,
    // so "IINC0" still parses as INC0.
    function automatic state_t start_state(input logic [7:0] b);
        case (b)
            ASC_I:   return S_I;
            ASC_D:   return S_D;
            ASC_C:   return S_C;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/inc_dec_parser.sv
// rtl/inc_dec_parser.sv - ASCII command parser FSM for inc_dec_bank
//
// Ports:
//   clk     clock, state advances on rising edge
//   rst_n   asynchronous active-low reset, forces IDLE
//   data    ASCII byte, considered only when valid=1
//   valid   byte qualifier
//   op      combinational opcode, non-OP_NONE on the cycle a valid in-range digit completes a command
//   ch      channel index carried by the digit byte (meaningful with op/bad)
//   bad     combinational strobe, a complete opcode was followed by a digit >= NCH
module inc_dec_parser
    import inc_dec_pkg::*;
#(
    parameter int NCH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output op_t        op,
    output logic [3:0] ch,
    output logic       bad
);

    state_t state_q;
    state_t state_d;
    logic   is_digit;
    logic   in_range;

    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value.
    assign ch       = data[3:0];
    assign is_digit = (data >= ASC_0) && (data <= ASC_9);
    assign in_range = int'(data[3:0]) < NCH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op      = OP_NONE;
        bad     = 1'b0;
        if (valid) begin
            // Default: the byte did not continue the command; retry it as a start byte.
            state_d = start_state(data);
            case (state_q)
                S_I:  if (data == ASC_N) state_d = S_IN;
                S_IN: if (data == ASC_C) state_d = W_INC;
                S_D:  if (data == ASC_E) state_d = S_DE;
                S_DE: if (data == ASC_C) state_d = W_DEC;
                S_C:  if (data == ASC_L) state_d = S_CL;
                S_CL: if (data == ASC_R) state_d = W_CLR;
                W_INC, W_DEC, W_CLR: begin
                    if (is_digit) begin
                        state_d = IDLE;
                        if (in_range) begin
                            case (state_q)
                                W_INC:   op = OP_INC;
                                W_DEC:   op = OP_DEC;
                                default: op = OP_CLR;
                            endcase
                        end else begin
                            bad = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/inc_dec_bank.sv
// rtl/inc_dec_bank.sv - bank of NCH up/down counters driven by ASCII INC/DEC/CLR commands
//
// Ports:
//   clk     clock, all state updates on rising edge
//   rst_n   asynchronous active-low reset
//   data    ASCII command byte
//   valid   byte accepted on a rising edge where valid=1
//   cnt     packed counters, channel k at [k*CNT_W +: CNT_W]
//   evt     one-cycle pulse, a command executed
//   evt_ch  channel of the last executed command, holds until the next evt
//   lim     one-cycle pulse, the executed command hit a counter limit
//   bad_ch  one-cycle pulse, a complete opcode was followed by a digit >= NCH
//
// Configuration:
//   INC_DEC_BANK_WRAP_EN  defined: counters wrap at the limits (lim pulses on wrap)
//                         undefined: counters saturate at the limits (lim pulses, value held)
module inc_dec_bank
    import inc_dec_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           data,
    input  logic                 valid,
    output logic [NCH*CNT_W-1:0] cnt,
    output logic                 evt,
    output logic [3:0]           evt_ch,
    output logic                 lim,
    output logic                 bad_ch
);

    op_t                           op;
    logic [3:0]                    ch;
    logic                          bad_s;
    logic [NCH-1:0][CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]              cur;
    logic [CNT_W-1:0]              nxt;
    logic                          hit;

    inc_dec_parser #(
        .NCH (NCH)
    ) u_parser (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (data),
        .valid (valid),
        .op    (op),
        .ch    (ch),
        .bad   (bad_s)
    );

    assign cnt = cnt_q;

    // Next value of the selected channel and whether it sits at a limit.
    always_comb begin
        cur = '0;
        for (int k = 0; k < NCH; k++) begin
            if (ch == 4'(k)) cur = cnt_q[k];
        end
        nxt = cur;
        hit = 1'b0;
        case (op)
            OP_INC: begin
                hit = &cur;
`ifdef INC_DEC_BANK_WRAP_EN
                nxt = cur + CNT_W'(1);
`else
                nxt = hit ? cur : cur + CNT_W'(1);
`endif
            end
            OP_DEC: begin
                hit = (cur == '0);
`ifdef INC_DEC_BANK_WRAP_EN
                nxt = cur - CNT_W'(1);
`else
                nxt = hit ? cur : cur - CNT_W'(1);
`endif
            end
            OP_CLR: begin
                nxt = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            evt    <= 1'b0;
            evt_ch <= 4'd0;
            lim    <= 1'b0;
            bad_ch <= 1'b0;
        end else begin
            evt    <= 1'b0;
            lim    <= 1'b0;
            bad_ch <= bad_s;
            if (op != OP_NONE) begin
                evt    <= 1'b1;
                evt_ch <= ch;
                lim    <= hit;
                for (int k = 0; k < NCH; k++) begin
                    if (ch == 4'(k)) cnt_q[k] <= nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_inc_dec_bank.sv
// tb/tb_inc_dec_bank.sv - scoreboard testbench for inc_dec_bank (NCH=4, CNT_W=16)
module tb_inc_dec_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic [63:0] cnt;
    logic        evt;
    logic [3:0]  evt_ch;
    logic        lim;
    logic        bad_ch;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        bit          bad;
        bit          lim;
        logic [3:0]  ch;
        logic [63:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

`ifdef INC_DEC_BANK_WRAP_EN
    localparam logic [15:0] DEC_FROM_0 = 16'hFFFF;
    localparam bit          WRAP = 1'b1;
`else
    localparam logic [15:0] DEC_FROM_0 = 16'h0000;
    localparam bit          WRAP = 1'b0;
`endif

    inc_dec_bank #(
        .NCH   (4),
        .CNT_W (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data   (data),
        .valid  (valid),
        .cnt    (cnt),
        .evt    (evt),
        .evt_ch (evt_ch),
        .lim    (lim),
        .bad_ch (bad_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) begin
            data  = s[i];
            valid = 1'b1;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        data  = 8'h00;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_evt(input logic [3:0] ch, input logic [63:0] c, input bit l);
        exp_t e;
        e.bad = 1'b0;
        e.lim = l;
        e.ch  = ch;
        e.cnt = c;
        sb.push_back(e);
    endtask

    task automatic push_bad(input logic [63:0] c);
        exp_t e;
        e.bad = 1'b1;
        e.lim = 1'b0;
        e.ch  = 4'd0;
        e.cnt = c;
        sb.push_back(e);
    endtask

    // Monitor: every evt/bad_ch pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (evt || bad_ch)) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse actual evt=%0b bad_ch=%0b required none", evt, bad_ch);
            end else begin
                mon_e = sb.pop_front();
                check("pulse_kind", {62'd0, bad_ch, evt}, mon_e.bad ? 64'd2 : 64'd1);
                check("cnt", cnt, mon_e.cnt);
                check("lim", {63'd0, lim}, {63'd0, mon_e.lim});
                if (!mon_e.bad) check("evt_ch", {60'd0, evt_ch}, {60'd0, mon_e.ch});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        check("rst_cnt", cnt, 64'd0);
        check("rst_evt", {63'd0, evt}, 64'd0);
        check("rst_evt_ch", {60'd0, evt_ch}, 64'd0);
        check("rst_lim", {63'd0, lim}, 64'd0);
        check("rst_bad_ch", {63'd0, bad_ch}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // INC2 with valid every cycle
        push_evt(4'd2, {16'd0, 16'd1, 16'd0, 16'd0}, 1'b0);
        send("INC2");

        // "IN", three valid-low cycles, "C1"
        send("IN");
        idle(3);
        push_evt(4'd1, {16'd0, 16'd1, 16'd1, 16'd0}, 1'b0);
        send("C1");

        // DEC at zero: saturate (default) or wrap
        push_evt(4'd0, {16'd0, 16'd1, 16'd1, DEC_FROM_0}, 1'b1);
        send("DEC0");

        // Mismatch recovery and back-to-back commands on channel 3
        push_evt(4'd3, {16'd1, 16'd1, 16'd1, DEC_FROM_0}, 1'b0);
        push_evt(4'd3, {16'd2, 16'd1, 16'd1, DEC_FROM_0}, 1'b0);
        push_evt(4'd3, {16'd0, 16'd1, 16'd1, DEC_FROM_0}, 1'b0);
        send("IINC3DEINC3CLR3");

        // Out-of-range channel
        push_bad({16'd0, 16'd1, 16'd1, DEC_FROM_0});
        send("INC7");
        idle(2);

        // Asynchronous reset after a partial "DE", away from any clock edge
        send("DE");
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_cnt", cnt, 64'd0);
        check("async_rst_evt_ch", {60'd0, evt_ch}, 64'd0);
        check("async_rst_flags", {61'd0, evt, lim, bad_ch}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send("C0");
        idle(2);
        push_evt(4'd0, {48'd0, DEC_FROM_0}, 1'b1);
        send("DEC0");

        // Back-to-back INC0 INC0
        if (WRAP) begin
            push_evt(4'd0, 64'd0, 1'b1);
            push_evt(4'd0, 64'd1, 1'b0);
        end else begin
            push_evt(4'd0, 64'd1, 1'b0);
            push_evt(4'd0, 64'd2, 1'b0);
        end
        send("INC0INC0");
        idle(4);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/inc_dec_bank.md
INC_DEC_BANK -- requirements
Module: inc_dec_bank

Interface
REQ-001 Parameter NCH, default 4, number of counter channels (1..10).
REQ-002 Parameter CNT_W, default 16, width of each counter (2..32).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data  input  8  ASCII byte; ignored unless valid=1.
REQ-006 valid  input  1  byte on data is accepted on a rising edge where valid=1.
REQ-007 cnt  output  NCH*CNT_W  packed counters; channel k occupies bits [k*CNT_W +: CNT_W].
REQ-008 evt  output  1  registered one-cycle pulse: a command executed.
REQ-009 evt_ch  output  4  channel of the last executed command; holds until next evt.
REQ-010 lim  output  1  registered one-cycle pulse: executed command hit a counter limit (saturate or wrap).
REQ-011 bad_ch  output  1  registered one-cycle pulse: a complete opcode was followed by a digit >= NCH.

Function
REQ-012 Commands: "INC<d>", "DEC<d>", "CLR<d>"; <d> is an ASCII digit '0'..'9' selecting channel d.
REQ-013 Parser states: IDLE, S_I, S_IN, S_D, S_DE, S_C, S_CL, W_INC, W_DEC, W_CLR.
REQ-014 Transitions on accepted 'I'/'N'/'C' etc.: IDLE-I->S_I-N->S_IN-C->W_INC; IDLE-D->S_D-E->S_DE-C->W_DEC; IDLE-C->S_C-L->S_CL-R->W_CLR.
REQ-015 Mismatch in any state: the byte is re-evaluated as a start byte ('I'->S_I, 'D'->S_D, 'C'->S_C, else IDLE); "IINC0" and "DEINC0" execute INC on channel 0.
REQ-016 In W_* states: digit d<NCH executes the command on channel d, then IDLE; digit d>=NCH pulses bad_ch, then IDLE; non-digit re-evaluated per REQ-015, no command.
REQ-017 No accepted byte (valid=0): state, counters and flags hold; evt, lim, bad_ch deassert.
REQ-018 Latency: command executes on the edge accepting the digit; cnt, evt, evt_ch, lim visible from that edge (one cycle after digit presented).
REQ-019 INC adds 1, DEC subtracts 1, CLR writes 0; only the selected channel changes, others hold.
REQ-020 Default limit behaviour: INC at 2^CNT_W-1 and DEC at 0 leave the counter unchanged and pulse lim; CLR never pulses lim.
REQ-021 Back-to-back commands on consecutive cycles ("INC0INC0") both execute; no dead cycles.

Reset
REQ-022 rst_n=0 forces parser to IDLE, all cnt=0, evt=0, evt_ch=0, lim=0, bad_ch=0 immediately, independent of clk.
REQ-023 Reset mid-command discards the partial command; first accepted byte after release is evaluated from IDLE.

Configuration
REQ-024 Macro INC_DEC_BANK_WRAP_EN defined: INC at max yields 0, DEC at 0 yields 2^CNT_W-1, lim pulses on each wrap.
REQ-025 Macro undefined: saturating behaviour of REQ-020.

Structure
REQ-026 Package inc_dec_pkg holds ASCII constants ('I','N','C','D','E','L','R','0'), parser state enum and opcode enum (OP_NONE, OP_INC, OP_DEC, OP_CLR).
REQ-027 Sub-module inc_dec_parser holds the FSM and emits opcode, channel index and bad_ch strobe; inc_dec_bank holds counters and flags.

Verification
REQ-028 Reset, then "INC2" with valid=1 every cycle -> cnt[2]=1, evt one pulse, evt_ch=2, others 0.
REQ-029 "IN", valid=0 three cycles, "C1" -> cnt[1]=1; valid-low cycles produce no evt.
REQ-030 cnt[0]=0, "DEC0" -> cnt[0]=0, lim pulse (default); with WRAP_EN -> cnt[0]=16'hFFFF, lim pulse.
REQ-031 "IINC3DEINC3CLR3" with NCH=4 -> cnt[3] 1, 2, 0 after each digit, three evt pulses.
REQ-032 "INC7" with NCH=4 -> bad_ch pulse, no counter change, no evt.
REQ-033 rst_n low asynchronously after "DE" -> outputs 0 immediately; then "C0" -> no command; "DEC0" -> lim pulse, cnt[0]=0.
